// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the register-bank arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int DATA_W        = 8;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_REG_COUNT = 8;

endpackage

// File: rtl/reg_bank_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo NUM_REQ.
// Latency: combinational.
// Backpressure: none; the caller decides when to act on the grant.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  // Scan upward from the pointer; one extra sum bit keeps the wrap correct
  // when NUM_REQ is not a power of two.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    logic             found;
    grant = '0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Serialises single-register reads/writes from NUM_REQ requesters onto a save/load bank; optional REG_ARB_LOCK_EN adds req_lock.
// Latency: grant in IDLE cycle N, bank strobe in N+1, ack pulse in N+2; one transaction per 3 cycles.
// Backpressure: requesters hold req until ack; losers wait, at most NUM_REQ-1 transactions each.
module reg_bank_arbiter
  import reg_arb_pkg::*;
#(
  parameter int UUID      = 0,
  parameter     NAME      = "",
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int REG_COUNT = DEF_REG_COUNT,
  localparam int ADDR_W   = $clog2(REG_COUNT),
  localparam int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
`ifdef REG_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]         req_lock,
`endif
  output logic [NUM_REQ-1:0]         ack,
  output logic [DATA_W-1:0]          rdata,
  output logic [REG_COUNT-1:0]       reg_save,
  output logic [REG_COUNT-1:0]       reg_load,
  output logic [DATA_W-1:0]          bus_wdata,
  input  logic [DATA_W-1:0]          bus_rdata
);

  // UUID and NAME only identify the instance; negative UUIDs are not meaningful.
  if (NUM_REQ < 2 || NUM_REQ > 8 || REG_COUNT < 2 || REG_COUNT > 16 ||
      (REG_COUNT & (REG_COUNT - 1)) != 0 || UUID < 0 || $bits(NAME) < 0) begin : g_bad_cfg
    $error("reg_bank_arbiter: unsupported NUM_REQ/REG_COUNT/UUID");
  end

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    win_idx;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;
  logic [NUM_REQ-1:0]  pick_req;
  logic [NUM_REQ-1:0]  pick_grant;
  logic [IDX_W-1:0]    pick_idx;
  logic                grant_any;

`ifdef REG_ARB_LOCK_EN
  logic                locked;
  logic [IDX_W-1:0]    lock_idx;
  logic                lock_hold;

  // A held lock narrows arbitration to the owner, but only while it still requests.
  assign lock_hold = locked && req[lock_idx];
  assign pick_req  = lock_hold ? (req & (NUM_REQ'(1) << lock_idx)) : req;
`else
  assign pick_req  = req;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (pick_req),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign grant_any = (state == IDLE) && (|pick_grant);

  // Next state plus the bank strobes and ack, all decoded from the latched winner.
  always_comb begin
    state_nxt = state;
    reg_save  = '0;
    reg_load  = '0;
    bus_wdata = '0;
    ack       = '0;
    case (state)
      IDLE: begin
        if (grant_any) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (win_we) begin
          reg_save[win_addr] = 1'b1;
          bus_wdata          = win_wdata;
        end else begin
          reg_load[win_addr] = 1'b1;
        end
        state_nxt = DONE;
      end
      DONE: begin
        ack[win_idx] = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Latch the winner's request on grant so later input changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      win_idx   <= '0;
      win_we    <= 1'b0;
      win_addr  <= '0;
      win_wdata <= '0;
    end else if (grant_any) begin
      win_idx   <= pick_idx;
      win_we    <= req_we[pick_idx];
      win_addr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
      win_wdata <= req_wdata[pick_idx*DATA_W +: DATA_W];
      ptr       <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
    end
  end

  // Capture the wired bank output at the edge closing a read access; held otherwise.
  always_ff @(posedge clk) begin
    if (rst)                          rdata <= '0;
    else if (state == ACCESS && !win_we) rdata <= bus_rdata;
  end

`ifdef REG_ARB_LOCK_EN
  // Lock is decided at each DONE and dropped early if the owner stops requesting.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked   <= 1'b0;
      lock_idx <= '0;
    end else if (state == DONE) begin
      locked   <= req_lock[win_idx];
      lock_idx <= win_idx;
    end else if (state == IDLE && locked && !req[lock_idx]) begin
      locked   <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter with a behavioural register bank.
// Directed scenarios plus random traffic against a transaction-level model.
// Inputs driven 1 time unit after posedge, outputs sampled on negedge.
module tb_reg_bank_arbiter;
  localparam int NR = 4;
  localparam int RC = 8;
  localparam int AW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req, req_we;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*8-1:0]   req_wdata;
  logic [NR-1:0]     ack;
  logic [7:0]        rdata;
  logic [RC-1:0]     reg_save, reg_load;
  logic [7:0]        bus_wdata, bus_rdata;
`ifdef REG_ARB_LOCK_EN
  logic [NR-1:0]     req_lock;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] bank [RC];
  logic       bank_clr;

  always #5 clk = ~clk;

  reg_bank_arbiter #(.UUID(0), .NAME("tb"), .NUM_REQ(NR), .REG_COUNT(RC)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata),
`ifdef REG_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .ack(ack), .rdata(rdata), .reg_save(reg_save), .reg_load(reg_load),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  // Register bank: capture on Save, wired-OR output on Load
  always @(posedge clk) begin
    for (int i = 0; i < RC; i++) begin
      if (bank_clr) bank[i] <= 8'h00;
      else if (reg_save[i]) bank[i] <= bus_wdata;
    end
  end

  always_comb begin
    bus_rdata = 8'h00;
    for (int j = 0; j < RC; j++) if (reg_load[j]) bus_rdata = bus_rdata | bank[j];
  end

  function automatic int rr_winner(input logic [NR-1:0] r, input int p);
    for (int k = 0; k < NR; k++) if (r[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic we, input int addr, input logic [7:0] wd);
    req_we[i] = we;
    req_addr[i*AW +: AW] = AW'(addr);
    req_wdata[i*8 +: 8] = wd;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Stimulus only: one transaction, req dropped in the cycle after ack
  task automatic one_txn(input int i, input logic we, input int addr, input logic [7:0] wd);
    @(posedge clk); #1;
    set_req(i, we, addr, wd); req[i] = 1'b1;
    repeat (3) @(posedge clk);
    #1 req[i] = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; req = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (ack !== 4'b0) begin miscompares++; $display("FAIL rst_ack: got %b exp 0000", ack); end
    vectors++; if (rdata !== 8'h00) begin miscompares++; $display("FAIL rst_rdata: got %h exp 00", rdata); end
    vectors++; if (reg_save !== 8'h00) begin miscompares++; $display("FAIL rst_save: got %h exp 00", reg_save); end
    vectors++; if (reg_load !== 8'h00) begin miscompares++; $display("FAIL rst_load: got %h exp 00", reg_load); end
    vectors++; if (bus_wdata !== 8'h00) begin miscompares++; $display("FAIL rst_wdata: got %h exp 00", bus_wdata); end
    @(posedge clk); #1;
    rst = 1'b0; req = '0; bank_clr = 1'b0;
  endtask

  task automatic test_write_read();
    do_reset();
    @(posedge clk); #1;
    set_req(0, 1'b1, 3, 8'hA5); req[0] = 1'b1;
    @(negedge clk);
    vectors++; if (ack !== 4'b0) begin miscompares++; $display("FAIL wr_n_ack: got %b exp 0000", ack); end
    @(negedge clk);
    vectors++; if (reg_save !== 8'h08) begin miscompares++; $display("FAIL wr_save: got %h exp 08", reg_save); end
    vectors++; if (reg_load !== 8'h00) begin miscompares++; $display("FAIL wr_load: got %h exp 00", reg_load); end
    vectors++; if (bus_wdata !== 8'hA5) begin miscompares++; $display("FAIL wr_bus: got %h exp a5", bus_wdata); end
    @(negedge clk);
    vectors++; if (ack !== 4'b0001) begin miscompares++; $display("FAIL wr_ack: got %b exp 0001", ack); end
    vectors++; if (bank[3] !== 8'hA5) begin miscompares++; $display("FAIL wr_bank: got %h exp a5", bank[3]); end
    @(posedge clk); #1 req[0] = 1'b0;
    @(posedge clk); #1;
    set_req(0, 1'b0, 3, 8'h00); req[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (reg_load !== 8'h08) begin miscompares++; $display("FAIL rd_load: got %h exp 08", reg_load); end
    vectors++; if (reg_save !== 8'h00) begin miscompares++; $display("FAIL rd_save: got %h exp 00", reg_save); end
    @(negedge clk);
    vectors++; if (ack !== 4'b0001) begin miscompares++; $display("FAIL rd_ack: got %b exp 0001", ack); end
    vectors++; if (rdata !== 8'hA5) begin miscompares++; $display("FAIL rd_data: got %h exp a5", rdata); end
    @(posedge clk); #1 req[0] = 1'b0;
  endtask

  task automatic test_contention();
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, i, 8'h00);
    req = '1;
    for (int t = 0; t < 17; t++) begin
      logic [NR-1:0] e;
      logic [NR-1:0] seen;
      @(negedge clk);
      e = '0;
      if (t >= 2 && (t - 2) % 3 == 0 && (t - 2) / 3 < 5) e[order[(t - 2) / 3]] = 1'b1;
      seen = ack;
      vectors++; if (ack !== e) begin miscompares++; $display("FAIL cont_ack t=%0d: got %b exp %b", t, ack, e); end
      @(posedge clk); #1;
      req = req & ~seen;
      if (t == 3) req[0] = 1'b1;
    end
    req = '0;
  endtask

  task automatic test_order();
    do_reset();
    one_txn(0, 1'b1, 5, 8'h11);              // pointer now 1
    @(posedge clk); #1;
    set_req(1, 1'b1, 5, 8'h3C); set_req(2, 1'b0, 5, 8'h00); req[2:1] = 2'b11;
    repeat (3) @(negedge clk);
    vectors++; if (ack !== 4'b0010) begin miscompares++; $display("FAIL ord1_first: got %b exp 0010", ack); end
    @(posedge clk); #1 req[1] = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (ack !== 4'b0100) begin miscompares++; $display("FAIL ord1_second: got %b exp 0100", ack); end
    vectors++; if (rdata !== 8'h3C) begin miscompares++; $display("FAIL ord1_rdata: got %h exp 3c", rdata); end
    @(posedge clk); #1 req[2] = 1'b0;        // pointer now 3
    one_txn(1, 1'b1, 5, 8'h11);              // pointer now 2
    @(posedge clk); #1;
    set_req(1, 1'b1, 5, 8'h3C); set_req(2, 1'b0, 5, 8'h00); req[2:1] = 2'b11;
    repeat (3) @(negedge clk);
    vectors++; if (ack !== 4'b0100) begin miscompares++; $display("FAIL ord2_first: got %b exp 0100", ack); end
    vectors++; if (rdata !== 8'h11) begin miscompares++; $display("FAIL ord2_rdata: got %h exp 11", rdata); end
    @(posedge clk); #1 req[2] = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (ack !== 4'b0010) begin miscompares++; $display("FAIL ord2_second: got %b exp 0010", ack); end
    vectors++; if (rdata !== 8'h11) begin miscompares++; $display("FAIL ord2_hold: got %h exp 11", rdata); end
    @(posedge clk); #1 req[1] = 1'b0;
    @(negedge clk);
    vectors++; if (bank[5] !== 8'h3C) begin miscompares++; $display("FAIL ord2_bank: got %h exp 3c", bank[5]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(posedge clk); #1;
    set_req(0, 1'b1, 2, 8'h55); req[0] = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    vectors++; if (reg_save !== 8'h04) begin miscompares++; $display("FAIL mid_save: got %h exp 04", reg_save); end
    @(posedge clk); #1;
    rst = 1'b0; req[0] = 1'b0;
    @(negedge clk);
    vectors++; if (ack !== 4'b0) begin miscompares++; $display("FAIL mid_ack: got %b exp 0000", ack); end
    vectors++; if ((reg_save | reg_load) !== 8'h00) begin miscompares++; $display("FAIL mid_strobe: got %h exp 00", reg_save | reg_load); end
    vectors++; if (bus_wdata !== 8'h00) begin miscompares++; $display("FAIL mid_bus: got %h exp 00", bus_wdata); end
    @(negedge clk);
    vectors++; if (ack !== 4'b0) begin miscompares++; $display("FAIL mid_ack2: got %b exp 0000", ack); end
    @(posedge clk); #1;
    set_req(0, 1'b0, 1, 8'h00); set_req(1, 1'b0, 1, 8'h00); req[1:0] = 2'b11;
    repeat (3) @(negedge clk);
    vectors++; if (ack !== 4'b0001) begin miscompares++; $display("FAIL mid_ptr: got %b exp 0001", ack); end
    @(posedge clk); #1 req[0] = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (ack !== 4'b0010) begin miscompares++; $display("FAIL mid_next: got %b exp 0010", ack); end
    @(posedge clk); #1 req[1] = 1'b0;
  endtask

`ifdef REG_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    @(posedge clk); #1;
    set_req(0, 1'b0, 1, 8'h00); set_req(1, 1'b0, 2, 8'h00);
    req_lock = 4'b0001; req[1:0] = 2'b11;
    for (int t = 0; t < 10; t++) begin
      logic [NR-1:0] e;
      logic [NR-1:0] seen;
      @(negedge clk);
      e = (t == 2 || t == 5) ? 4'b0001 : (t == 8) ? 4'b0010 : 4'b0000;
      seen = ack;
      vectors++; if (ack !== e) begin miscompares++; $display("FAIL lock_ack t=%0d: got %b exp %b", t, ack, e); end
      @(posedge clk); #1;
      if (t == 2) begin
        req_lock = '0;
        seen[0] = 1'b0;                      // owner keeps requesting for its second access
      end
      req = req & ~seen;
    end
    req = '0;
  endtask
`endif

  task automatic test_random();
    logic [7:0] mbank [RC];
    int mptr, mbusy, exp_cyc, exp_req, w, a;
    logic exp_rd;
    logic [7:0] exp_rdata;
    do_reset();
    @(posedge clk); #1 bank_clr = 1'b1;
    @(posedge clk); #1 bank_clr = 1'b0;
    for (int i = 0; i < RC; i++) mbank[i] = 8'h00;
    mptr = 0; mbusy = 0; exp_cyc = -1; exp_req = 0; exp_rd = 1'b0; exp_rdata = 8'h00;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic [NR-1:0] e;
      logic [NR-1:0] seen;
      @(negedge clk);
      seen = ack;
      vectors++; if ($countones(reg_save | reg_load) > 1) begin miscompares++; $display("FAIL rnd_strobe c=%0d: got %h exp <=1 bit", cyc, reg_save | reg_load); end
      e = '0;
      if (cyc == exp_cyc) e[exp_req] = 1'b1;
      vectors++; if (ack !== e) begin miscompares++; $display("FAIL rnd_ack c=%0d: got %b exp %b", cyc, ack, e); end
      if (cyc == exp_cyc && exp_rd) begin
        vectors++; if (rdata !== exp_rdata) begin miscompares++; $display("FAIL rnd_rdata c=%0d: got %h exp %h", cyc, rdata, exp_rdata); end
      end
      // Transaction-level model: an idle arbiter grants from this cycle's requests
      if (mbusy > 0) mbusy--;
      else if (req != '0) begin
        w = rr_winner(req, mptr);
        mptr = (w + 1) % NR;
        mbusy = 2;
        exp_cyc = cyc + 2;
        exp_req = w;
        a = int'(req_addr[w*AW +: AW]);
        exp_rd = !req_we[w];
        if (req_we[w]) mbank[a] = req_wdata[w*8 +: 8];
        exp_rdata = mbank[a];
      end
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (seen[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) begin
          set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, RC - 1)), 8'($urandom));
          req[i] = 1'b1;
        end
      end
    end
    req = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0; bank_clr = 1'b1;
`ifdef REG_ARB_LOCK_EN
    req_lock = '0;
`endif
    test_reset();
    test_write_read();
    test_contention();
    test_order();
    test_reset_mid();
`ifdef REG_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Round-robin arbiter that shares a bank of 8-bit save/load registers between several requesters, each issuing single-register read or write transactions. Each bank register has a `Save` strobe, a `Load` (output-enable) strobe, a shared `Save_value` bus and a shared wired `Output` bus. The block sits between the CPU-side requesters (decoder, ALU writeback, I/O) and the register bank. It serialises all accesses so that at most one `Save` or `Load` strobe is active per cycle.

## Interface
Parameters:
- UUID, 0, instance identifier, passed through unused
- NAME, "", instance name, passed through unused
- NUM_REQ, 4, number of requesters (2..8)
- REG_COUNT, 8, number of bank registers (power of two, ≤16); ADDR_W = clog2(REG_COUNT)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester transaction request; held until its ack
- req_we  in  NUM_REQ  per-requester: 1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  per-requester register index, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*8  per-requester write data, requester i at [i*8 +: 8]
- ack  out  NUM_REQ  one-hot completion pulse, one cycle
- rdata  out  8  read result; valid while ack is high for a read
- reg_save  out  REG_COUNT  one-hot `Save` strobes to the bank
- reg_load  out  REG_COUNT  one-hot `Load` (output enable) strobes to the bank
- bus_wdata  out  8  shared `Save_value` bus
- bus_rdata  in  8  shared `Output` bus (wired from the bank)

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any req is high, the round-robin picker selects a winner.
  - The winner's index, we, addr and wdata are latched and the FSM goes to ACCESS.
  - Otherwise the FSM stays in IDLE.
- ACCESS (exactly 1 cycle):
  - Write: reg_save[addr]=1 and bus_wdata=latched wdata. The bank captures the value at the closing edge.
  - Read: reg_load[addr]=1. bus_rdata is captured into rdata at the closing edge.
  - Transition to DONE.
- DONE (exactly 1 cycle): ack[winner]=1, then transition to IDLE.
- Round-robin:
  - A priority pointer holds the index of the highest-priority requester.
  - On entering ACCESS, the pointer becomes winner+1 mod NUM_REQ.
  - The pointer resets to 0.
- Outputs outside ACCESS: reg_save=0, reg_load=0, bus_wdata=0.
- rdata holds its last captured value; it is not cleared after a write.
- Input changes after the latch in IDLE have no effect on the transaction in flight.
- A req dropped before ack is a protocol violation. The transaction still completes and ack still pulses.

## Timing
- Reset values: FSM=IDLE, pointer=0, ack=0, rdata=0x00, reg_save=0, reg_load=0, bus_wdata=0x00.
- Latency:
  - req high in IDLE cycle N → ACCESS in cycle N+1 → ack in cycle N+2.
  - A written value is visible on the bank register from cycle N+2.
- Throughput: one transaction per 3 cycles.
  - The requester must drop req in the cycle after ack.
  - A req still high in the IDLE cycle after DONE is treated as a new request.
- Simultaneous requests: the lowest index at or after the pointer wins. The losers wait; each waits at most NUM_REQ-1 transactions.
- Write then read of the same register by different requesters: executed in grant order. The read returns the new value when the write was granted first.
- rst during ACCESS or DONE:
  - The transaction is aborted; no ack is issued.
  - Strobes are 0 from the cycle after rst.
  - A write whose ACCESS edge coincides with rst may or may not be captured by the bank; the bank's own reset clears it.
- Invariant: at most one bit is set across reg_save|reg_load in any cycle.

## Configuration
- REG_ARB_LOCK_EN defined:
  - Adds an input `req_lock` (NUM_REQ bits).
  - If the winner's req_lock is high during its DONE cycle, the next IDLE grants only that requester, provided it requests. This gives atomic read-modify-write.
  - Other requesters are held off while the lock is held.
  - The lock releases at the first DONE where req_lock is low, or at the first IDLE where the locked requester has req low.
- REG_ARB_LOCK_EN undefined: the port is absent and arbitration is pure round-robin.

## Structure
- Package reg_arb_pkg:
  - state enum (IDLE, ACCESS, DONE)
  - DATA_W=8
  - default NUM_REQ and REG_COUNT constants
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant and encoded index.
- The top level holds the FSM, the latches, the pointer and the strobe decode.

## Test plan
- Single write then read: req0 writes 0xA5 to reg 3 (ack0 at N+2, reg_save=0x08 in ACCESS); req0 then reads reg 3 → rdata=0xA5 with ack0.
- Contention: req0..req3 all high from reset → acks in order 0,1,2,3, each 3 cycles apart; re-asserting req0 after its ack is served after req3.
- Write/read ordering: req1 writes 0x3C to reg 5 while req2 reads reg 5 simultaneously, pointer=1 → req2 returns 0x3C; with pointer=2 → req2 returns the old value.
- Reset mid-transaction: rst asserted in the ACCESS cycle → no ack, all strobes 0 next cycle, pointer=0.
- Strobe invariant: random traffic for 10k cycles → popcount(reg_save|reg_load) ≤ 1 every cycle, and ack is one-hot or zero.
- REG_ARB_LOCK_EN: req0 holds lock across two transactions while req1 requests → req0 is acked twice before req1.
